// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: MEM-stage SRAM access states and defaults.
package arm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } mem_state_t;

   localparam int unsigned ADDR_BASE_DEF   = 1024;
   localparam int unsigned WAIT_CYCLES_DEF = 3;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase counter for one 16-bit SRAM access: load, count down, flag zero.
module sram_wait_counter #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && !zero)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// ARM MEM stage: LDR/STR as two half-word accesses to a multi-cycle 16-bit SRAM.
module mem_stage_sram_ctrl
   import arm_pkg::*;
#(
   parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wb_en_in,
   input  logic               mem_r_en_in,
   input  logic               mem_w_en_in,
   input  logic [31:0]        alu_res_in,
   input  logic [31:0]        val_rm_in,
   input  logic [3:0]         dst_in,
   output logic               wb_en_out,
   output logic               mem_r_en_out,
   output logic [31:0]        alu_res_out,
   output logic [31:0]        mem_r_val_out,
   output logic [3:0]         dst_out,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_wdata,
   input  logic [15:0]        sram_rdata,
   output logic               sram_we_n
);

   localparam logic [1:0] CNT_INIT = 2'(WAIT_CYCLES - 1);

   mem_state_t  state;
   logic        req;
   logic        is_read;
   logic        cnt_zero;
   logic        cnt_load;
   logic        cnt_dec;
   logic [31:0] word_off;

   assign req     = mem_r_en_in | mem_w_en_in;
   assign is_read = mem_r_en_in & ~mem_w_en_in;

   assign cnt_load = ((state == IDLE) && req) || ((state == LO) && cnt_zero);
   assign cnt_dec  = ((state == LO) || (state == HI)) && !cnt_zero;

   sram_wait_counter #(.WIDTH(2)) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (CNT_INIT),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         sram_we_n     <= 1'b1;
         mem_r_val_out <= '0;
      end else begin
         case (state)
            IDLE: if (req) begin
               state     <= LO;
               // Write strobe is registered; asserted on entry, held through HI.
               sram_we_n <= ~mem_w_en_in;
            end
            LO: if (cnt_zero) begin
               state <= HI;
               if (is_read) mem_r_val_out[15:0] <= sram_rdata;
            end
            HI: if (cnt_zero) begin
               state     <= DONE;
               sram_we_n <= 1'b1;
               if (is_read) mem_r_val_out[31:16] <= sram_rdata;
            end
            DONE: state <= IDLE;
            default: begin
               state     <= IDLE;
               sram_we_n <= 1'b1;
            end
         endcase
      end
   end

   assign word_off = (alu_res_in - 32'(ADDR_BASE)) >> 2;

   always_comb begin
      sram_addr  = '0;
      sram_wdata = '0;
      case (state)
         LO: begin
            sram_addr = SRAM_AW'({word_off, 1'b0});
            if (mem_w_en_in) sram_wdata = val_rm_in[15:0];
         end
         HI: begin
            sram_addr = SRAM_AW'({word_off, 1'b1});
            if (mem_w_en_in) sram_wdata = val_rm_in[31:16];
         end
         default: ;
      endcase
   end

   assign ready        = ((state == IDLE) && !req) || (state == DONE);
   assign wb_en_out    = wb_en_in & ready;
   assign mem_r_en_out = mem_r_en_in & ready;
   assign alu_res_out  = alu_res_in;
   assign dst_out      = dst_in;

endmodule
